// File: rtl/frame_mux_packer_pkg.sv
// Shared definitions for the multi-channel frame packer: header constants,
// FSM state encoding and the header word layout.
package frame_pack_pkg;

  localparam logic [31:0] MAGIC_DEFAULT    = 32'h53544B32;
  localparam logic [31:0] PAD_WORD_DEFAULT = 32'hDEADDEAD;

  localparam int CH_W   = 4;
  localparam int SEQ_W  = 8;
  localparam int SIZE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    PAD,
    DONE
  } state_t;

  function automatic logic [31:0] hdr1_word(input logic [CH_W-1:0]   ch,
                                            input logic [SEQ_W-1:0]  seq,
                                            input logic [SIZE_W-1:0] size);
    return {4'b0000, ch, seq, size};
  endfunction

endpackage

// File: rtl/frame_mux_packer_if.sv
// Packet output stream of the frame packer: data, framing, length and the
// downstream ready that closes the handshake.
interface frame_mux_packer_if #(
  parameter int DW   = 32,
  parameter int LENW = 16
);
  logic [DW-1:0]   out_data;
  logic            out_vld;
  logic            out_sop;
  logic            out_eop;
  logic            out_rdy;
  logic [LENW+1:0] pkt_len;

  modport master (
    output out_data, out_vld, out_sop, out_eop, pkt_len,
    input  out_rdy
  );

  modport slave (
    input  out_data, out_vld, out_sop, out_eop, pkt_len,
    output out_rdy
  );
endinterface

// File: rtl/frame_mux_packer_rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting after the last
// granted index; the pointer moves only when the grant is taken.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] last_q, last_d;

  always_comb begin : pick
    int            idx;
    logic [IW-1:0] pos;
    logic          found;
    grant = '0;
    index = '0;
    found = 1'b0;
    idx   = 0;
    pos   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N) idx = idx - N;
      pos = IW'(idx);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance) last_d = index;
  end

  // Pointer starts on the last channel so channel 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IW'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/frame_mux_packer.sv
// Multi-channel frame packer: latches frame announcements, arbitrates
// round-robin and emits header-prefixed packets, padding stalled sources.
module frame_mux_packer
  import frame_pack_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          DW       = 32,
  parameter int          LENW     = 16,
  parameter logic [DW-1:0] MAGIC    = DW'(MAGIC_DEFAULT),
  parameter logic [DW-1:0] PAD_WORD = DW'(PAD_WORD_DEFAULT),
  parameter int          TIMEOUT  = 1024
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      i_ch_en,
  input  logic [NCH-1:0]      i_frame_ready,
  input  logic [NCH*LENW-1:0] i_frame_size,
  input  logic [NCH*DW-1:0]   i_in_data,
  input  logic [NCH-1:0]      i_in_vld,
  output logic [NCH-1:0]      o_in_rdy,
  frame_mux_packer_if.master  out_if,
  output logic [7:0]          o_drop_cnt,
  output logic                o_err_pad
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [NCH-1:0]  ready_prev_q;
  logic [NCH-1:0]  pending_q, pending_d;
  logic [LENW-1:0] size_q [NCH];
  logic [LENW-1:0] size_d [NCH];
  logic [7:0]      seq_q [NCH];
  logic [7:0]      seq_d [NCH];
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [IW-1:0]   ch_q, ch_d;
  logic [LENW-1:0] cur_size_q, cur_size_d;
  logic [LENW-1:0] remaining_q, remaining_d;
  logic [7:0]      cur_seq_q, cur_seq_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            err_pad_q, err_pad_d;

  logic [NCH-1:0]  rise, req, grant;
  logic [IW-1:0]   grant_idx;
  logic            advance;
  logic [DW-1:0]   sel_data;
  logic            sel_vld;
  logic [LENW-1:0] grant_size;
  logic [7:0]      grant_seq;
  logic [LENW+1:0] pkt_len_w;

  assign rise    = i_frame_ready & ~ready_prev_q;
  assign req     = pending_q & i_ch_en;
  assign advance = (state_q == IDLE) && (|req);

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .grant   (grant),
    .index   (grant_idx)
  );

  always_comb begin
    sel_data   = '0;
    sel_vld    = 1'b0;
    grant_size = '0;
    grant_seq  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == IW'(k)) begin
        sel_data = i_in_data[k*DW +: DW];
        sel_vld  = i_in_vld[k];
      end
      if (grant_idx == IW'(k)) begin
        grant_size = size_q[k];
        grant_seq  = seq_q[k];
      end
    end
  end

  // A grant frees its pending slot first, so an edge on the same cycle
  // re-arms the channel instead of counting as a drop.
  always_comb begin
    pending_d  = pending_q;
    size_d     = size_q;
    seq_d      = seq_q;
    drop_cnt_d = drop_cnt_q;
    for (int k = 0; k < NCH; k++) begin
      if (advance && grant[k]) pending_d[k] = 1'b0;
      if (rise[k] && i_ch_en[k]) begin
        if (pending_d[k]) begin
          if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
        end else begin
          pending_d[k] = 1'b1;
          size_d[k]    = i_frame_size[k*LENW +: LENW];
        end
      end
      if (!i_ch_en[k]) pending_d[k] = 1'b0;
      if (state_q == DONE && ch_q == IW'(k)) seq_d[k] = cur_seq_q + 8'd1;
    end
  end

  assign pkt_len_w = ({2'b00, cur_size_q} + (LENW+2)'(2)) << 2;

  always_comb begin
    state_d         = state_q;
    ch_d            = ch_q;
    cur_size_d      = cur_size_q;
    cur_seq_d       = cur_seq_q;
    remaining_d     = remaining_q;
    idle_d          = idle_q;
    err_pad_d       = err_pad_q;
    out_if.out_data = '0;
    out_if.out_vld  = 1'b0;
    out_if.out_sop  = 1'b0;
    out_if.out_eop  = 1'b0;
    out_if.pkt_len  = '0;
    o_in_rdy        = '0;
    case (state_q)
      IDLE: begin
        idle_d = '0;
        if (advance) begin
          ch_d       = grant_idx;
          cur_size_d = grant_size;
          cur_seq_d  = grant_seq;
          state_d    = HDR0;
        end
      end
      HDR0: begin
        out_if.out_data = MAGIC;
        out_if.out_vld  = 1'b1;
        out_if.out_sop  = 1'b1;
        out_if.pkt_len  = pkt_len_w;
        if (out_if.out_rdy) state_d = HDR1;
      end
      HDR1: begin
        out_if.out_data = DW'(hdr1_word(CH_W'(ch_q), cur_seq_q, SIZE_W'(cur_size_q)));
        out_if.out_vld  = 1'b1;
        out_if.out_eop  = (cur_size_q == '0);
        if (out_if.out_rdy) begin
          remaining_d = cur_size_q;
          idle_d      = '0;
          state_d     = (cur_size_q == '0) ? DONE : DATA;
        end
      end
      DATA: begin
        out_if.out_data = sel_data;
        out_if.out_vld  = sel_vld;
        out_if.out_eop  = sel_vld && (remaining_q == LENW'(1));
        for (int k = 0; k < NCH; k++) begin
          if (ch_q == IW'(k)) o_in_rdy[k] = out_if.out_rdy;
        end
        // Only cycles with no valid word count towards the stall timeout.
        if (sel_vld && out_if.out_rdy) begin
          idle_d      = '0;
          remaining_d = remaining_q - LENW'(1);
          if (remaining_q == LENW'(1)) state_d = DONE;
        end else if (!sel_vld) begin
          if (idle_q == TW'(TIMEOUT - 1)) begin
            idle_d    = '0;
            err_pad_d = 1'b1;
            state_d   = PAD;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end
      end
      PAD: begin
        out_if.out_data = PAD_WORD;
        out_if.out_vld  = 1'b1;
        out_if.out_eop  = (remaining_q == LENW'(1));
        if (out_if.out_rdy) begin
          remaining_d = remaining_q - LENW'(1);
          if (remaining_q == LENW'(1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_prev_q <= '0;
      pending_q    <= '0;
      for (int k = 0; k < NCH; k++) begin
        size_q[k] <= '0;
        seq_q[k]  <= '0;
      end
      drop_cnt_q  <= '0;
      ch_q        <= '0;
      cur_size_q  <= '0;
      cur_seq_q   <= '0;
      remaining_q <= '0;
      idle_q      <= '0;
      err_pad_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_prev_q <= i_frame_ready;
      pending_q    <= pending_d;
      size_q       <= size_d;
      seq_q        <= seq_d;
      drop_cnt_q   <= drop_cnt_d;
      ch_q         <= ch_d;
      cur_size_q   <= cur_size_d;
      cur_seq_q    <= cur_seq_d;
      remaining_q  <= remaining_d;
      idle_q       <= idle_d;
      err_pad_q    <= err_pad_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
  assign o_err_pad  = err_pad_q;

endmodule

// File: tb/tb_frame_mux_packer.sv
// Randomized bench for frame_mux_packer: a packet-level model predicts every
// output word from the announced frames and the source data handed out.
module tb_frame_mux_packer;
  import frame_pack_pkg::*;

  localparam int NCH     = 4;
  localparam int DW      = 32;
  localparam int LENW    = 16;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] MAGIC_W = 32'h53544B32;
  localparam logic [31:0] PAD_W   = 32'hDEADDEAD;
  localparam int K_HDR  = 0;
  localparam int K_DATA = 1;
  localparam int K_PAD  = 2;

  typedef struct {
    logic [31:0] data;
    bit          sop;
    bit          eop;
    logic [17:0] len;
    int          kind;
    int          ch;
  } exp_t;

  logic                sys_clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      i_ch_en;
  logic [NCH-1:0]      i_frame_ready;
  logic [NCH*LENW-1:0] i_frame_size;
  logic [NCH*DW-1:0]   i_in_data;
  logic [NCH-1:0]      i_in_vld;
  logic [NCH-1:0]      o_in_rdy;
  logic [7:0]          o_drop_cnt;
  logic                o_err_pad;

  frame_mux_packer_if #(.DW(DW), .LENW(LENW)) out_if ();

  frame_mux_packer #(
    .NCH(NCH), .DW(DW), .LENW(LENW), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .i_ch_en       (i_ch_en),
    .i_frame_ready (i_frame_ready),
    .i_frame_size  (i_frame_size),
    .i_in_data     (i_in_data),
    .i_in_vld      (i_in_vld),
    .o_in_rdy      (o_in_rdy),
    .out_if        (out_if),
    .o_drop_cnt    (o_drop_cnt),
    .o_err_pad     (o_err_pad)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words_seen = 0;
  int rdy_mode = 0;
  bit gap_check = 0;
  bit directed_data = 0;

  exp_t        exp_q[$];
  logic [31:0] src_q[NCH][$];
  int          ann_size[NCH];
  int          ann_supply[NCH];
  int          seq_m[NCH];
  int          last_m;
  int          drop_m;
  bit          err_m;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) seq_m[k] = 0;
    last_m = NCH - 1;
    drop_m = 0;
    err_m  = 0;
  endtask

  // One packet: two header words, the words the source really supplies,
  // then filler for whatever the source never delivers.
  task automatic add_packet(input int ch, input int size, input int supply);
    exp_t        e;
    logic [31:0] w;
    e.data = MAGIC_W; e.sop = 1; e.eop = 0; e.len = 18'((size + 2) * 4);
    e.kind = K_HDR;   e.ch = ch;
    exp_q.push_back(e);
    e.data = {4'h0, 4'(ch), 8'(seq_m[ch]), 16'(size)};
    e.sop  = 0; e.eop = (size == 0); e.len = '0;
    exp_q.push_back(e);
    for (int i = 0; i < size; i++) begin
      e.eop = (i == size - 1);
      if (i < supply) begin
        w = directed_data ? 32'(i + 1) : $urandom;
        src_q[ch].push_back(w);
        e.data = w;     e.kind = K_DATA;
      end else begin
        e.data = PAD_W; e.kind = K_PAD;
        err_m  = 1;
      end
      exp_q.push_back(e);
    end
    seq_m[ch] = (seq_m[ch] + 1) % 256;
  endtask

  // Announces every channel in mask on the same cycle; packets follow in
  // round-robin order starting after the last served channel.
  task automatic applyStimulus(input logic [NCH-1:0] mask);
    int c;
    int granted;
    granted = last_m;
    for (int i = 1; i <= NCH; i++) begin
      c = (last_m + i) % NCH;
      if (mask[c]) begin
        add_packet(c, ann_size[c], ann_supply[c]);
        i_frame_size[c*LENW +: LENW] = LENW'(ann_size[c]);
        granted = c;
      end
    end
    last_m = granted;
    i_frame_ready = i_frame_ready | mask;
    tick(2);
    i_frame_ready = i_frame_ready & ~mask;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    tick(3);
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    checkOutput("drop_cnt", 64'(o_drop_cnt), 64'(drop_m));
    checkOutput("err_pad", 64'(o_err_pad), 64'(err_m));
  endtask

  task automatic expect_quiet();
    checkOutput("q_vld", 64'(out_if.out_vld), 64'd0);
    checkOutput("q_sop", 64'(out_if.out_sop), 64'd0);
    checkOutput("q_eop", 64'(out_if.out_eop), 64'd0);
    checkOutput("q_data", 64'(out_if.out_data), 64'd0);
    checkOutput("q_pkt_len", 64'(out_if.pkt_len), 64'd0);
    checkOutput("q_in_rdy", 64'(o_in_rdy), 64'd0);
    checkOutput("q_drop_cnt", 64'(o_drop_cnt), 64'd0);
    checkOutput("q_err_pad", 64'(o_err_pad), 64'd0);
  endtask

  // Sources: present the queue head with random gaps, hold it until taken.
  initial begin
    logic [NCH-1:0] xfer;
    forever begin
      @(negedge sys_clk);
      xfer = i_in_vld & o_in_rdy;
      @(posedge sys_clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
        if (xfer[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (!(i_in_vld[k] && !xfer[k])) begin
          if (src_q[k].size() > 0 && $urandom_range(0, 99) < 75) begin
            i_in_vld[k] = 1'b1;
            i_in_data[k*DW +: DW] = src_q[k][0];
          end else begin
            i_in_vld[k] = 1'b0;
          end
        end
      end
      case (rdy_mode)
        0:       out_if.out_rdy = 1'b1;
        1:       out_if.out_rdy = 1'($urandom_range(0, 1));
        default: out_if.out_rdy = ~out_if.out_rdy;
      endcase
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    exp_t        e;
    bit          prev_stall;
    logic [31:0] prev_data;
    int          prev_kind;
    int          last_cyc;
    prev_stall = 0; prev_data = '0; prev_kind = K_HDR; last_cyc = 0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        checkOutput("in_rdy_onehot", 64'($onehot0(o_in_rdy)), 64'd1);
        if (!out_if.out_rdy) checkOutput("in_rdy_gate", 64'(o_in_rdy), 64'd0);
        if (prev_stall) begin
          checkOutput("hold_vld", 64'(out_if.out_vld), 64'd1);
          checkOutput("hold_data", 64'(out_if.out_data), 64'(prev_data));
        end
        if (out_if.out_vld && out_if.out_rdy) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", 64'(out_if.out_vld), 64'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("word", 64'(out_if.out_data), 64'(e.data));
            checkOutput("sop", 64'(out_if.out_sop), 64'(e.sop));
            checkOutput("eop", 64'(out_if.out_eop), 64'(e.eop));
            if (e.sop) checkOutput("pkt_len", 64'(out_if.pkt_len), 64'(e.len));
            if (e.kind == K_DATA) checkOutput("in_rdy_sel", 64'(o_in_rdy), 64'd1 << e.ch);
            if (e.kind == K_PAD && prev_kind != K_PAD && gap_check)
              checkOutput("pad_gap", 64'(cyc - last_cyc), 64'(TIMEOUT + 1));
            prev_kind = e.kind;
            last_cyc  = cyc;
          end
        end
        prev_stall = out_if.out_vld && !out_if.out_rdy;
        prev_data  = out_if.out_data;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [NCH-1:0] mask;
    rst_n = 1'b0; i_ch_en = '1; i_frame_ready = '0; i_frame_size = '0;
    i_in_data = '0; i_in_vld = '0; out_if.out_rdy = 1'b1;
    model_reset();
    for (int k = 0; k < NCH; k++) begin ann_size[k] = 1; ann_supply[k] = 1; end
    repeat (2) @(negedge sys_clk);
    expect_quiet();
    @(posedge sys_clk); #2;
    rst_n = 1'b1;
    tick(2);

    $display("[TB] single channel, size 3, then sequence number 1");
    directed_data = 1; ann_size[0] = 3; ann_supply[0] = 3;
    applyStimulus(4'b0001);
    wait_drain(200);
    directed_data = 0; ann_size[0] = 2; ann_supply[0] = 2;
    applyStimulus(4'b0001);
    wait_drain(200);

    $display("[TB] round robin ch0+ch2, twice");
    for (int r = 0; r < 2; r++) begin
      ann_size[0] = $urandom_range(1, 5); ann_supply[0] = ann_size[0];
      ann_size[2] = $urandom_range(1, 5); ann_supply[2] = ann_size[2];
      applyStimulus(4'b0101);
      wait_drain(400);
    end

    $display("[TB] backpressure toggling, size 4");
    rdy_mode = 2; ann_size[1] = 4; ann_supply[1] = 4;
    applyStimulus(4'b0010);
    wait_drain(400);
    rdy_mode = 0;

    $display("[TB] source stall timeout");
    gap_check = 1; ann_size[1] = 5; ann_supply[1] = 2;
    applyStimulus(4'b0010);
    wait_drain(500);
    gap_check = 0;

    $display("[TB] dropped announcement keeps original size");
    ann_size[0] = 8; ann_supply[0] = 8;
    applyStimulus(4'b0001);
    tick(1);
    ann_size[3] = 2; ann_supply[3] = 2;
    applyStimulus(4'b1000);
    tick(1);
    i_frame_size[3*LENW +: LENW] = LENW'(7);
    i_frame_ready[3] = 1'b1;
    tick(2);
    i_frame_ready[3] = 1'b0;
    drop_m++;
    wait_drain(400);

    $display("[TB] announcement on disabled channel");
    i_ch_en[3] = 1'b0;
    n = words_seen;
    i_frame_size[3*LENW +: LENW] = LENW'(4);
    i_frame_ready[3] = 1'b1;
    tick(2);
    i_frame_ready[3] = 1'b0;
    tick(30);
    checkOutput("disabled_words", 64'(words_seen - n), 64'd0);
    i_ch_en[3] = 1'b1;
    tick(2);

    $display("[TB] zero-size frame");
    ann_size[2] = 0; ann_supply[2] = 0;
    applyStimulus(4'b0100);
    wait_drain(200);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 10; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < NCH; k++) begin
        ann_size[k]   = $urandom_range(0, 8);
        ann_supply[k] = ann_size[k];
      end
      rdy_mode = $urandom_range(0, 2);
      applyStimulus(mask);
      wait_drain(1500);
    end
    rdy_mode = 0;

    $display("[TB] reset during data phase");
    ann_size[2] = 6; ann_supply[2] = 6;
    applyStimulus(4'b0100);
    n = 0;
    while (exp_q.size() > 4 && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput("reached_data", 64'(exp_q.size() <= 4), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NCH; k++) src_q[k].delete();
    i_in_vld = '0;
    model_reset();
    @(negedge sys_clk);
    expect_quiet();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    @(negedge sys_clk);
    expect_quiet();
    tick(1);
    ann_size[0] = 3; ann_supply[0] = 3;
    ann_size[2] = 2; ann_supply[2] = 2;
    applyStimulus(4'b0101);
    wait_drain(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
